bitops_serial_tx: RTL and testbench
===================================

Name: bitops_serial_tx

Overview:
- Parallel-to-serial transmitter for the bit-op datapath: accepts a WIDTH-bit word on a valid/ready handshake and shifts it out on a single line.
- Frame: start bit, data LSB-first, optional even-parity bit (XOR-reduction of the word), stop bit.
- Acts as the transmit end feeding a serial link whose receiver rebuilds the word and checks parity with the same reduction ops.

Parameters:
- WIDTH, 4, data word width in bits; legal range 1 to 16.
- DIV, 4, clock cycles each serial bit is held; legal range 1 to 255.

Ports:
- clock  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- io_in_valid  input  1  io_in_data holds a word to send.
- io_in_ready  output  1  block can accept a word this cycle.
- io_in_data  input  WIDTH  word to transmit.
- io_tx  output  1  serial line, idle-high.
- io_busy  output  1  frame in progress.
- io_done  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset (reset=0, async): state IDLE, io_tx=1, io_in_ready=1, io_busy=0, io_done=0, bit counter=0, divider=0, shift register=0.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - io_in_ready=1, io_tx=1.
  - On io_in_valid&io_in_ready at edge t: latch io_in_data into the shift register; latch parity=^io_in_data; go to START at t+1.
- Bit timing: every non-IDLE state holds io_tx for exactly DIV cycles. An 8-bit divider counts 0..DIV-1; the state advances when the divider reaches DIV-1.
- START: io_tx=0.
- DATA:
  - io_tx=shift[0]; shift right by 1 at each bit boundary.
  - Bit counter runs 0..WIDTH-1. Leave DATA after bit WIDTH-1 to PARITY (feature on) or STOP (feature off).
- PARITY: io_tx=latched parity. With this bit, the total count of ones across data+parity is even.
- STOP:
  - io_tx=1.
  - io_done=1 on the final cycle of STOP only (divider==DIV-1).
  - Next state IDLE.
- Outputs by state: io_busy=1 in all non-IDLE states; io_in_ready=0 in all non-IDLE states.
- Frame length: (WIDTH+3)*DIV cycles with parity, (WIDTH+2)*DIV without, measured from the first START cycle to the last STOP cycle.
- Back-to-back throughput: after io_done, one IDLE cycle follows. A word presented in that cycle starts START on the next cycle. Minimum gap between frames is 1 idle-high cycle.
- Boundary conditions:
  - io_in_valid while busy is ignored; data is not captured and no error is flagged.
  - io_in_data changes mid-frame have no effect.
  - DIV=1: each state lasts one cycle; io_done coincides with the single STOP cycle.
  - WIDTH=1: DATA lasts one bit time.
  - Reset asserted mid-frame: io_tx goes to 1 and io_busy to 0 immediately (asynchronously); the partial frame is abandoned. After reset release the block is in IDLE, ready=1.
- All outputs are registered; no combinational path from io_in_valid to any output except io_in_ready, which is a pure state decode.

Optional Feature:
- Macro BITOPS_TX_PARITY_EN.
- Defined: PARITY state present; frame = start + WIDTH data + parity + stop.
- Undefined: PARITY state and parity register are not built; DATA goes directly to STOP; frame = start + WIDTH data + stop. Port list is unchanged in both builds.

Test Plan:
- Parity build, WIDTH=4, DIV=4, send 4'hA. io_tx holds each of 0,0,1,0,1,0,1 for 4 cycles (start, d0..d3, parity=0, stop). io_done high only in cycle 28 of the frame; io_busy high for all 28 cycles.
- Parity build, WIDTH=4, DIV=1, send 4'h7. io_tx sequence 0,1,1,1,0,1,1; parity bit=1; frame length 7 cycles.
- DIV=1, io_in_valid held high with 4'h1 then 4'h2. Two frames separated by exactly one idle cycle with io_tx=1. The second word is captured in that idle cycle.
- During a frame of 4'hF, drive io_in_valid=1 with 4'h0 for 10 cycles. io_in_ready stays 0, the transmitted data bits stay 1,1,1,1, and no second frame follows.
- Assert reset in the DATA state, 2 cycles into bit d1. io_tx=1 and io_busy=0 in the same cycle. After release, io_in_ready=1; a new word 4'h5 transmits correctly.
- Non-parity build, WIDTH=4, DIV=2, send 4'hC. io_tx = 0,0,0,1,1,1 at 2 cycles per bit; frame length 12 cycles; no parity bit.

Source files
------------

// File: rtl/bitops_serial_tx.sv
// Parallel-to-serial transmitter: start bit, LSB-first data, optional even parity, stop bit.
// Define BITOPS_TX_PARITY_EN to build the PARITY state and parity register.
module bitops_serial_tx #(
    parameter int WIDTH = 4,
    parameter int DIV   = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             io_in_valid,
    output logic             io_in_ready,
    input  logic [WIDTH-1:0] io_in_data,
    output logic             io_tx,
    output logic             io_busy,
    output logic             io_done
);

    localparam int         BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0] DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

`ifdef BITOPS_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, PARITY} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t            state, state_nxt;
    logic [7:0]        div_cnt, div_nxt;
    logic [BW-1:0]     bit_cnt, bit_nxt;
    logic [WIDTH-1:0]  shift, shift_nxt;
    logic              tx_nxt, busy_nxt, done_nxt;
    logic              bit_end;
`ifdef BITOPS_TX_PARITY_EN
    logic              par, par_nxt;
`endif

    assign bit_end     = (div_cnt == DIV_LAST);
    assign io_in_ready = (state == IDLE);

    always_comb begin
        state_nxt = state;
        div_nxt   = div_cnt;
        bit_nxt   = bit_cnt;
        shift_nxt = shift;
`ifdef BITOPS_TX_PARITY_EN
        par_nxt   = par;
`endif
        case (state)
            IDLE: begin
                if (io_in_valid) begin
                    shift_nxt = io_in_data;
`ifdef BITOPS_TX_PARITY_EN
                    par_nxt   = ^io_in_data;
`endif
                    div_nxt   = 8'd0;
                    bit_nxt   = '0;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    div_nxt   = 8'd0;
                    state_nxt = DATA;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    div_nxt   = 8'd0;
                    shift_nxt = shift >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        bit_nxt = '0;
`ifdef BITOPS_TX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end else begin
                        bit_nxt = bit_cnt + 1'b1;
                    end
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
`ifdef BITOPS_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    div_nxt   = 8'd0;
                    state_nxt = STOP;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    div_nxt   = 8'd0;
                    state_nxt = IDLE;
                end else begin
                    div_nxt = div_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // Outputs are registered, so they are decoded from the next state.
        tx_nxt = 1'b1;
        case (state_nxt)
            START:  tx_nxt = 1'b0;
            DATA:   tx_nxt = shift_nxt[0];
`ifdef BITOPS_TX_PARITY_EN
            PARITY: tx_nxt = par_nxt;
`endif
            default: tx_nxt = 1'b1;
        endcase
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == STOP) && (div_nxt == DIV_LAST);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            div_cnt <= 8'd0;
            bit_cnt <= '0;
            shift   <= '0;
`ifdef BITOPS_TX_PARITY_EN
            par     <= 1'b0;
`endif
            io_tx   <= 1'b1;
            io_busy <= 1'b0;
            io_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            div_cnt <= div_nxt;
            bit_cnt <= bit_nxt;
            shift   <= shift_nxt;
`ifdef BITOPS_TX_PARITY_EN
            par     <= par_nxt;
`endif
            io_tx   <= tx_nxt;
            io_busy <= busy_nxt;
            io_done <= done_nxt;
        end
    end

endmodule

// File: tb/tb_bitops_serial_tx.sv
// Directed bench for bitops_serial_tx: three instances at DIV=1, 2, 4 with WIDTH=4.
module tb_bitops_serial_tx;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [2:0] valid = '0;
    logic [3:0] data [3];
    logic [2:0] tx, busy, done, ready;

    int passed = 0;
    int total  = 0;

`ifdef BITOPS_TX_PARITY_EN
    localparam int NB = 7;
`else
    localparam int NB = 6;
`endif

    always #5 clock = ~clock;

    bitops_serial_tx #(.WIDTH(4), .DIV(1)) u_d1 (
        .clock(clock), .reset(reset), .io_in_valid(valid[0]), .io_in_ready(ready[0]),
        .io_in_data(data[0]), .io_tx(tx[0]), .io_busy(busy[0]), .io_done(done[0]));
    bitops_serial_tx #(.WIDTH(4), .DIV(2)) u_d2 (
        .clock(clock), .reset(reset), .io_in_valid(valid[1]), .io_in_ready(ready[1]),
        .io_in_data(data[1]), .io_tx(tx[1]), .io_busy(busy[1]), .io_done(done[1]));
    bitops_serial_tx #(.WIDTH(4), .DIV(4)) u_d4 (
        .clock(clock), .reset(reset), .io_in_valid(valid[2]), .io_in_ready(ready[2]),
        .io_in_data(data[2]), .io_tx(tx[2]), .io_busy(busy[2]), .io_done(done[2]));

    typedef struct {
        int         sel;
        int         div;
        logic [3:0] d;
        logic [7:0] seq;      // bit i = line level during bit time i
        int         noise_lo;
        int         noise_hi;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string nm, input int cyc, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s cycle %0d: got %b expected %b", nm, cyc, act, exp);
    endtask

    // Checks every cycle of a frame already started; we sit at the negedge of its first cycle.
    task automatic check_frame(input int sel, input int div, input logic [7:0] seq,
                               input int nlo, input int nhi, input string nm);
        for (int c = 0; c < NB * div; c++) begin
            check({nm, " tx"},   c, tx[sel],   seq[c / div]);
            check({nm, " busy"}, c, busy[sel], 1'b1);
            check({nm, " done"}, c, done[sel], c == NB * div - 1);
            if (c >= nlo && c <= nhi) begin
                check({nm, " ready"}, c, ready[sel], 1'b0);
                valid[sel] = 1'b1;
                data[sel]  = 4'h0;
            end else begin
                valid[sel] = 1'b0;
            end
            @(negedge clock);
        end
    endtask

    task automatic run_frame(input vec_t v, input string nm);
        check({nm, " ready pre"}, 0, ready[v.sel], 1'b1);
        valid[v.sel] = 1'b1;
        data[v.sel]  = v.d;
        @(negedge clock);
        valid[v.sel] = 1'b0;
        check_frame(v.sel, v.div, v.seq, v.noise_lo, v.noise_hi, nm);
        for (int k = 0; k < 3; k++) begin
            check({nm, " idle tx"},    k, tx[v.sel],    1'b1);
            check({nm, " idle busy"},  k, busy[v.sel],  1'b0);
            check({nm, " idle ready"}, k, ready[v.sel], 1'b1);
            @(negedge clock);
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) data[i] = 4'h0;
`ifdef BITOPS_TX_PARITY_EN
        vecs[0] = '{2, 4, 4'hA, 8'h54, -1, -1};
        vecs[1] = '{0, 1, 4'h7, 8'h6E, -1, -1};
        vecs[2] = '{1, 2, 4'hC, 8'h58, -1, -1};
        vecs[3] = '{2, 4, 4'hF, 8'h5E,  2, 11};
        vecs[4] = '{0, 1, 4'h5, 8'h4A, -1, -1};
        vecs[5] = '{1, 2, 4'h1, 8'h62, -1, -1};
`else
        vecs[0] = '{2, 4, 4'hA, 8'h34, -1, -1};
        vecs[1] = '{0, 1, 4'h7, 8'h2E, -1, -1};
        vecs[2] = '{1, 2, 4'hC, 8'h38, -1, -1};
        vecs[3] = '{2, 4, 4'hF, 8'h3E,  2, 11};
        vecs[4] = '{0, 1, 4'h5, 8'h2A, -1, -1};
        vecs[5] = '{1, 2, 4'h1, 8'h22, -1, -1};
`endif

        // Reset state
        #12;
        for (int i = 0; i < 3; i++) begin
            check("rst tx",    i, tx[i],    1'b1);
            check("rst ready", i, ready[i], 1'b1);
            check("rst busy",  i, busy[i],  1'b0);
            check("rst done",  i, done[i],  1'b0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) run_frame(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back on DIV=1: valid held, second word captured in the single idle cycle
        valid[0] = 1'b1;
        data[0]  = 4'h1;
        @(negedge clock);
        data[0]  = 4'h2;
`ifdef BITOPS_TX_PARITY_EN
        check_frame(0, 1, 8'h62, -1, -1, "b2b f1");
`else
        check_frame(0, 1, 8'h22, -1, -1, "b2b f1");
`endif
        valid[0] = 1'b1;
        check("b2b gap tx",    0, tx[0],    1'b1);
        check("b2b gap busy",  0, busy[0],  1'b0);
        check("b2b gap ready", 0, ready[0], 1'b1);
        @(negedge clock);
        valid[0] = 1'b0;
`ifdef BITOPS_TX_PARITY_EN
        check_frame(0, 1, 8'h64, -1, -1, "b2b f2");
`else
        check_frame(0, 1, 8'h24, -1, -1, "b2b f2");
`endif
        for (int k = 0; k < 3; k++) begin
            check("b2b end tx",   k, tx[0],   1'b1);
            check("b2b end busy", k, busy[0], 1'b0);
            @(negedge clock);
        end

        // Reset mid-frame on DIV=4: 2 cycles into d1 (frame cycle 10), d1 of 4'h5 is 0
        valid[2] = 1'b1;
        data[2]  = 4'h5;
        @(negedge clock);
        valid[2] = 1'b0;
        repeat (10) @(negedge clock);
        check("mid tx pre",   0, tx[2],   1'b0);
        check("mid busy pre", 0, busy[2], 1'b1);
        reset = 1'b0;
        #1;
        check("mid tx async",   0, tx[2],   1'b1);
        check("mid busy async", 0, busy[2], 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid ready post", 0, ready[2], 1'b1);
        check("mid busy post",  0, busy[2],  1'b0);
`ifdef BITOPS_TX_PARITY_EN
        run_frame('{2, 4, 4'h5, 8'h4A, -1, -1}, "post rst");
`else
        run_frame('{2, 4, 4'h5, 8'h2A, -1, -1}, "post rst");
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
